bam_product_accumulator: RTL and testbench
==========================================

BAM_PRODUCT_ACCUMULATOR -- requirements
Module: bam_product_accumulator

Interface
REQ-001 SHALL have parameter PROD_W, default 16, width of the approximate-multiplier product consumed.
REQ-002 SHALL have parameter ACC_W, default 24, accumulator width; legal range PROD_W..32.
REQ-003 SHALL have parameter CNT_W, default 8, beat-counter width.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port prod_in, input, PROD_W, unsigned product from the upstream broken-array multiplier.
REQ-007 SHALL have port in_valid, input, 1, prod_in is valid this cycle.
REQ-008 SHALL have port in_last, input, 1, qualified by in_valid; marks the final beat of a frame.
REQ-009 SHALL have port in_ready, output, 1, the block accepts a beat this cycle.
REQ-010 SHALL have port acc_out, output, ACC_W, frame sum.
REQ-011 SHALL have port beat_cnt, output, CNT_W, number of beats in the frame.
REQ-012 SHALL have port ovf, output, 1, the frame sum saturated.
REQ-013 SHALL have port out_valid, output, 1, acc_out, beat_cnt and ovf are valid.
REQ-014 SHALL have port out_ready, input, 1, the downstream stage accepts the result.

Function
REQ-015 SHALL implement two states: ACCUM (collecting beats) and HOLD (result presented).
REQ-016 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0; in HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-017 A beat SHALL be accepted only when in_valid and in_ready are both 1; prod_in is ignored otherwise.
REQ-018 On acceptance: acc <= sat(acc + zero-extended prod_in); cnt <= cnt + 1, saturating at 2^CNT_W-1.
REQ-019 sat(x): if x > 2^ACC_W-1, the result SHALL be 2^ACC_W-1 and a sticky ovf flag SHALL be set for the rest of the frame.
REQ-020 An accepted beat with in_last=1 SHALL move the FSM to HOLD; out_valid SHALL rise on the next cycle and include that beat (latency 1).
REQ-021 In HOLD, acc_out, beat_cnt and ovf SHALL stay stable until the handshake out_valid&out_ready completes.
REQ-022 On the HOLD handshake, acc, cnt and ovf SHALL clear to 0 and the FSM SHALL return to ACCUM; in_ready SHALL be 1 on the following cycle.
REQ-023 In ACCUM, acc_out, beat_cnt and ovf SHALL expose the running values, but they are don't-care while out_valid=0.
REQ-024 in_last without in_valid SHALL have no effect.
REQ-025 A single-beat frame (first beat has in_last=1) SHALL be legal and produce beat_cnt=1.
REQ-026 Arithmetic SHALL be unsigned. The implementation SHALL NOT assume that the always-zero low product bits (zeroed by the multiplier's vertical cut) are zero.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL enter ACCUM with acc=0, cnt=0 and ovf=0; out_valid=0, acc_out=0, beat_cnt=0 and in_ready=1 from the next cycle.
REQ-028 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending result; no out_valid pulse SHALL follow.
REQ-029 rst SHALL take priority over any simultaneous beat or handshake.

Verification
REQ-030 Three beats 0x0400, 0x0C00, 0x7C00, with in_last on the third and out_ready=1 -> one cycle later: out_valid=1, acc_out=0x008C00, beat_cnt=3, ovf=0; in_ready=1 two cycles after the last beat.
REQ-031 With ACC_W=18: five beats of 0xFC00 -> after four beats the running sum is 0x3F000 with no overflow; the final result is acc_out=0x3FFFF, ovf=1, beat_cnt=5.
REQ-032 Back-pressure: result pending with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs unchanged, no beats consumed; out_ready=1 -> handshake, then the next frame starts from 0.
REQ-033 Single beat 0xA400 with in_last=1 -> acc_out=0x00A400, beat_cnt=1.
REQ-034 Reset after two accepted beats of a frame -> no out_valid; a new frame of 0x0800 (last) yields acc_out=0x000800, beat_cnt=1.
REQ-035 Gaps: in_valid toggled 1,0,0,1(last) with beats 0x1000 and 0x2000 -> acc_out=0x003000, beat_cnt=2.

Source files
------------

// File: rtl/bam_product_accumulator_if.sv
// bam_product_accumulator_if: beat input and frame-result handshake bundle
interface bam_product_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
);
  logic [PROD_W-1:0] prod_in;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  beat_cnt;
  logic              ovf;
  logic              out_valid;
  logic              out_ready;
  modport master (
    output prod_in, in_valid, in_last, out_ready,
    input  in_ready, acc_out, beat_cnt, ovf, out_valid
  );
  modport slave (
    input  prod_in, in_valid, in_last, out_ready,
    output in_ready, acc_out, beat_cnt, ovf, out_valid
  );
endinterface

// File: rtl/bam_product_accumulator.sv
// bam_product_accumulator: saturating per-frame sum of approximate products
module bam_product_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst,
  bam_product_accumulator_if.slave bus
);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic ovf_q;
  logic take, give;
  logic [ACC_W:0] sum;
  // handshakes, next state and the widened sum whose top bit flags saturation
  always_comb begin
    take = bus.in_valid && state == ACCUM;
    give = bus.out_ready && state == HOLD;
    sum = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.prod_in};
    state_nxt = (take && bus.in_last) ? HOLD : give ? ACCUM : state;
    bus.in_ready = state == ACCUM;
    bus.out_valid = state == HOLD;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else state <= state_nxt;
  end
  // frame accumulator, beat counter and sticky overflow
  always_ff @(posedge clk) begin
    if (rst || give) begin
      acc <= '0;
      cnt <= '0;
      ovf_q <= 1'b0;
    end else if (take) begin
      acc <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
      ovf_q <= ovf_q | sum[ACC_W];
      cnt <= &cnt ? cnt : cnt + 1'b1;
    end
  end
  assign bus.acc_out = acc;
  assign bus.beat_cnt = cnt;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_bam_product_accumulator.sv
// tb_bam_product_accumulator: directed and randomized frames against a frame-sum model
module tb_bam_product_accumulator;
  localparam int PW = 16;
  localparam int AW = 18;
  localparam int CW = 4;
  localparam longint AMAX = (64'd1 << AW) - 1;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  longint m_sum;
  int m_cnt;
  bam_product_accumulator_if #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW)) bus ();
  bam_product_accumulator #(.PROD_W(PW), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] exp_acc();
    return 32'(m_sum > AMAX ? AMAX : m_sum);
  endfunction
  task automatic model_clear();
    m_sum = 0;
    m_cnt = 0;
  endtask
  task automatic send(input logic [PW-1:0] p, input logic last);
    bus.prod_in = p;
    bus.in_valid = 1'b1;
    bus.in_last = last;
    check("in_ready_beat", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    m_sum += longint'(p);
    if (m_cnt < CMAX) m_cnt++;
    bus.in_valid = 1'b0;
    bus.in_last = 1'($urandom);
    bus.prod_in = PW'($urandom);
    check("out_valid_after_beat", 32'(bus.out_valid), 32'(last));
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      bus.in_valid = 1'b0;
      bus.in_last = 1'($urandom);
      bus.prod_in = PW'($urandom);
      @(posedge clk);
      #1;
      check("out_valid_idle", 32'(bus.out_valid), 0);
      check("in_ready_idle", 32'(bus.in_ready), 1);
    end
  endtask
  task automatic check_result(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 1);
    check({tag, "_acc"}, 32'(bus.acc_out), exp_acc());
    check({tag, "_cnt"}, 32'(bus.beat_cnt), 32'(m_cnt));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(m_sum > AMAX));
  endtask
  task automatic collect(input string tag, input int stall);
    check_result(tag);
    repeat (stall) begin
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_last = 1'($urandom);
      bus.prod_in = PW'($urandom);
      check("in_ready_hold", 32'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      check_result({tag, "_stall"});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    model_clear();
    check("out_valid_after_hs", 32'(bus.out_valid), 0);
    check("in_ready_after_hs", 32'(bus.in_ready), 1);
    check("acc_cleared", 32'(bus.acc_out), 0);
    check("cnt_cleared", 32'(bus.beat_cnt), 0);
  endtask
  task automatic pulse_reset(input logic with_beat);
    rst = 1'b1;
    bus.in_valid = with_beat;
    bus.in_last = 1'b1;
    bus.prod_in = 16'hFFFF;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_acc", 32'(bus.acc_out), 0);
    check("rst_cnt", 32'(bus.beat_cnt), 0);
    check("rst_ovf", 32'(bus.ovf), 0);
  endtask
  initial begin
    rst = 1'b1;
    bus.prod_in = '0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    pulse_reset(1'b0);
    bus.out_ready = 1'b1;
    send(16'h0400, 1'b0);
    send(16'h0C00, 1'b0);
    send(16'h7C00, 1'b1);
    check("three_beat_acc", 32'(bus.acc_out), 32'h008C00);
    collect("three_beat", 0);
    for (int i = 0; i < 4; i++) send(16'hFC00, 1'b0);
    check("run4_acc", 32'(bus.acc_out), 32'h3F000);
    check("run4_ovf", 32'(bus.ovf), 0);
    send(16'hFC00, 1'b1);
    check("sat_acc", 32'(bus.acc_out), 32'h3FFFF);
    check("sat_ovf", 32'(bus.ovf), 1);
    check("sat_cnt", 32'(bus.beat_cnt), 5);
    collect("sat", 5);
    send(16'hA400, 1'b1);
    check("single_acc", 32'(bus.acc_out), 32'h00A400);
    check("single_cnt", 32'(bus.beat_cnt), 1);
    collect("single", 1);
    send(16'h1234, 1'b0);
    send(16'h4321, 1'b0);
    pulse_reset(1'b0);
    idle(3);
    send(16'h0800, 1'b1);
    check("after_rst_acc", 32'(bus.acc_out), 32'h000800);
    collect("after_rst", 0);
    send(16'h1000, 1'b0);
    idle(2);
    send(16'h2000, 1'b1);
    check("gap_acc", 32'(bus.acc_out), 32'h003000);
    check("gap_cnt", 32'(bus.beat_cnt), 2);
    collect("gap", 0);
    send(16'h5555, 1'b1);
    pulse_reset(1'b0);
    idle(2);
    pulse_reset(1'b1);
    idle(1);
    for (int i = 0; i < 20; i++) send(16'h0001, i == 19);
    check("cnt_sat", 32'(bus.beat_cnt), CMAX);
    collect("cnt_sat", 0);
    for (int f = 0; f < 40; f++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int b = 0; b < len; b++) begin
        idle($urandom_range(0, 2));
        send($urandom_range(0, 1) ? PW'($urandom) : PW'($urandom_range(0, 255) << 8), b == len - 1);
      end
      collect("rand", $urandom_range(0, 3));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
